acc_control_fsm: RTL and testbench
==================================

Name: acc_control_fsm

Overview:
- Multicycle control unit for the 16-bit accumulator CPU.
- Drives the select and ALU-op inputs of the ALU datapath (SrcA, SrcB, ALUOP) and all register-write and memory strobes.
- Consumes the IR opcode, the ALU Zero flag and a memory ready handshake.
- Sequences each instruction through fetch, decode, execute and writeback states.

Parameters:
- TIMEOUT, 15: max consecutive cycles waiting for MemReady before a bus fault; counter width is $clog2(TIMEOUT+1).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge resets the block.
- Opcode  in  4  IR[15:12]; valid from DECODE onward.
- Zero  in  1  ALU zero flag, combinational from datapath.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite, IRWrite, ALUOutWrite, MDRWrite, ACCWrite, SPWrite  out  1 each  register enables.
- MemRead, MemWrite  out  1 each  memory request strobes.
- MemAddrSrc  out  2  memory address select: 0=PC, 1=ZE, 2=SP, 3=ALUOut.
- PCSrc  out  2  PC input select: 0=ALU Out, 1=ALUOut reg, 2=ZE.
- ACCSrc  out  1  ACC input select: 0=ALU Out, 1=MDR.
- SrcA  out  3  0=PC, 1=ACC, 2=SP.
- SrcB  out  4  0=const 2, 1=SE, 2=MDR, 3=ZE, 4=SL1.
- ALUOP  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 5=PASSA.
- Halted  out  1  core stopped.
- Fault  out  1  illegal opcode or memory timeout.

Behaviour:
- Moore outputs decoded from the state register.
- Unlisted strobes are 0; unlisted selects are 0.
- Reset:
  - state <= FETCH; wait counter <= 0; Halted=0; Fault=0.
  - All strobes are forced 0 while reset=0.
  - Reset mid-instruction abandons it; no partial write occurs after the reset edge.
- Opcodes: 0 HALT, 1 LW, 2 SW, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 ADDI, 8 BEQZ, 9 J, A PUSH, B POP; C-F are illegal.
- Memory handshake:
  - A memory state holds MemRead or MemWrite and its address select until MemReady=1; the completing strobes fire in that same cycle.
  - The wait counter increments each non-ready cycle and clears on leaving the state.
  - When the counter reaches TIMEOUT, go to HALT with Fault=1.
  - MemReady in the first cycle gives zero wait.
- FETCH: MemRead, MemAddrSrc=0, SrcA=0, SrcB=0, ADD. On ready: IRWrite, PCWrite, PCSrc=0 (PC+2), then DECODE.
- DECODE: SrcA=0, SrcB=4, ADD, ALUOutWrite (branch target).
  - 1,3-6 -> MEMRD; 2 -> SW; 7 -> ADDI; 8 -> BEQZ; 9 -> JUMP; A -> PUSHSP; B -> POPRD.
  - 0 -> HALT; C-F -> HALT with Fault=1.
- MEMRD: MemRead, MemAddrSrc=1. On ready: MDRWrite. Opcode 1 -> LWWB; otherwise -> ALUMEM.
- LWWB: ACCWrite, ACCSrc=1 -> FETCH.
- ALUMEM: SrcA=1, SrcB=2, ALUOP = ADD/SUB/AND/OR for opcode 3/4/5/6, ACCWrite, ACCSrc=0 -> FETCH.
- SW: MemWrite, MemAddrSrc=1; on ready -> FETCH.
- ADDI: SrcA=1, SrcB=1, ADD, ACCWrite -> FETCH.
- BEQZ: SrcA=1, ALUOP=PASSA. If Zero: PCWrite, PCSrc=1. -> FETCH.
- JUMP: PCWrite, PCSrc=2 -> FETCH.
- PUSHSP: SrcA=2, SrcB=0, SUB, SPWrite -> PUSHWR.
- PUSHWR: MemWrite, MemAddrSrc=2; on ready -> FETCH.
- POPRD: MemRead, MemAddrSrc=2; on ready: MDRWrite -> POPWB.
- POPWB: ACCWrite, ACCSrc=1, SrcA=2, SrcB=0, ADD, SPWrite -> FETCH.
- HALT: Halted=1, Fault sticky; all strobes 0; only reset exits.
- Latencies with zero wait, in cycles: ADDI/BEQZ/J = 3; LW/ALU-mem/POP = 4; SW/PUSH = 3/4.

Decomposition:
- Package acc_ctrl_pkg holds the state enum, opcode constants, SrcA/SrcB/ALUOP/MemAddrSrc/PCSrc encodings, and the TIMEOUT default.
- Sub-module acc_mem_wait: wait counter plus timeout compare, with ports CLK, reset, busy, MemReady, timeout.

Test Plan:
- Reset held 2 cycles, then released with MemReady=1 -> FETCH; first cycle MemRead=1, MemAddrSrc=0; strobes were 0 during reset.
- ADD (opcode 3), MemReady=1 -> states FETCH, DECODE, MEMRD, ALUMEM; ACCWrite=1 with ALUOP=0, SrcB=2 in cycle 4.
- LW with MemReady low for 3 cycles -> MEMRD held 4 cycles with MemRead=1; MDRWrite only in the ready cycle.
- BEQZ with Zero=1 -> PCWrite=1, PCSrc=1; with Zero=0 -> PCWrite=0, return to FETCH.
- PUSH then POP -> SPWrite with SUB, then MemWrite at SP; after POP, ACCSrc=1 and SPWrite with ADD in the same cycle.
- Opcode 0xD -> Halted=1, Fault=1. Separately, TIMEOUT=15 with MemReady never asserted -> HALT, Fault=1 after 15 wait cycles.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator CPU multicycle control unit:
// state encodings, IR opcodes, datapath select/ALU-op encodings and the
// default memory-wait timeout.
package acc_ctrl_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // Control states (legacy-compatible constant encodings)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMRD  = 4'd2;
    localparam logic [3:0] S_LWWB   = 4'd3;
    localparam logic [3:0] S_ALUMEM = 4'd4;
    localparam logic [3:0] S_SW     = 4'd5;
    localparam logic [3:0] S_ADDI   = 4'd6;
    localparam logic [3:0] S_BEQZ   = 4'd7;
    localparam logic [3:0] S_JUMP   = 4'd8;
    localparam logic [3:0] S_PUSHSP = 4'd9;
    localparam logic [3:0] S_PUSHWR = 4'd10;
    localparam logic [3:0] S_POPRD  = 4'd11;
    localparam logic [3:0] S_POPWB  = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;

    // Opcodes (IR[15:12]); 0xC-0xF are illegal
    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h1;
    localparam logic [3:0] OP_SW   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_PUSH = 4'hA;
    localparam logic [3:0] OP_POP  = 4'hB;

    // Memory address select
    localparam logic [1:0] MA_PC     = 2'd0;
    localparam logic [1:0] MA_ZE     = 2'd1;
    localparam logic [1:0] MA_SP     = 2'd2;
    localparam logic [1:0] MA_ALUOUT = 2'd3;

    // PC input select
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_ZE     = 2'd2;

    // ACC input select
    localparam logic ACC_ALU = 1'b0;
    localparam logic ACC_MDR = 1'b1;

    // ALU A operand select
    localparam logic [2:0] A_PC  = 3'd0;
    localparam logic [2:0] A_ACC = 3'd1;
    localparam logic [2:0] A_SP  = 3'd2;

    // ALU B operand select
    localparam logic [3:0] B_TWO = 4'd0;
    localparam logic [3:0] B_SE  = 4'd1;
    localparam logic [3:0] B_MDR = 4'd2;
    localparam logic [3:0] B_ZE  = 4'd3;
    localparam logic [3:0] B_SL1 = 4'd4;

    // ALU operations
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_PASSA = 3'd5;

    // States that hold a memory request until MemReady
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_SW) ||
               (s == S_PUSHWR) || (s == S_POPRD);
    endfunction

endpackage

// File: rtl/acc_mem_wait.sv
// Memory wait counter with timeout detection.
// Ports:
//   CLK      in  clock
//   reset    in  synchronous active-low reset
//   busy     in  controller is in a memory-request state
//   MemReady in  memory completes the request this cycle
//   timeout  out this non-ready cycle is the TIMEOUT-th consecutive one
module acc_mem_wait
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic CLK,
    input  logic reset,
    input  logic busy,
    input  logic MemReady,
    output logic timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // The counter would reach TIMEOUT on this edge: leave the state now.
    assign timeout = busy && !MemReady && (count_q == LAST_WAIT);

    always_comb begin
        count_d = '0;
        if (busy && !MemReady && !timeout) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/acc_control_fsm.sv
// Multicycle control unit for the 16-bit accumulator CPU. Moore-style
// decode of the state register drives datapath selects, ALU op and all
// register/memory strobes; memory states wait on MemReady with a timeout.
// Ports:
//   CLK, reset             clock, synchronous active-low reset
//   Opcode, Zero, MemReady IR opcode, ALU zero flag, memory handshake
//   PCWrite..SPWrite       register write enables
//   MemRead, MemWrite      memory request strobes
//   MemAddrSrc, PCSrc, ACCSrc, SrcA, SrcB, ALUOP  datapath selects
//   Halted, Fault          core stopped / illegal opcode or bus timeout
module acc_control_fsm
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       ALUOutWrite,
    output logic       MDRWrite,
    output logic       ACCWrite,
    output logic       SPWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] MemAddrSrc,
    output logic [1:0] PCSrc,
    output logic       ACCSrc,
    output logic [2:0] SrcA,
    output logic [3:0] SrcB,
    output logic [2:0] ALUOP,
    output logic       Halted,
    output logic       Fault
);

    logic [3:0] state_q, state_d;
    logic       fault_q, fault_d;
    logic       busy;
    logic       timeout;

    assign busy = is_mem_state(state_q);

    acc_mem_wait #(
        .TIMEOUT(TIMEOUT)
    ) u_mem_wait (
        .CLK     (CLK),
        .reset   (reset),
        .busy    (busy),
        .MemReady(MemReady),
        .timeout (timeout)
    );

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        ALUOutWrite = 1'b0;
        MDRWrite    = 1'b0;
        ACCWrite    = 1'b0;
        SPWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemAddrSrc  = MA_PC;
        PCSrc       = PC_ALU;
        ACCSrc      = ACC_ALU;
        SrcA        = A_PC;
        SrcB        = B_TWO;
        ALUOP       = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                MemAddrSrc = MA_PC;
                SrcA       = A_PC;
                SrcB       = B_TWO;
                ALUOP      = ALU_ADD;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = PC_ALU;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                SrcA        = A_PC;
                SrcB        = B_SL1;
                ALUOP       = ALU_ADD;
                ALUOutWrite = 1'b1;
                case (Opcode)
                    OP_HALT: state_d = S_HALT;
                    OP_LW, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MEMRD;
                    OP_SW:   state_d = S_SW;
                    OP_ADDI: state_d = S_ADDI;
                    OP_BEQZ: state_d = S_BEQZ;
                    OP_J:    state_d = S_JUMP;
                    OP_PUSH: state_d = S_PUSHSP;
                    OP_POP:  state_d = S_POPRD;
                    default: begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                MemAddrSrc = MA_ZE;
                if (MemReady) begin
                    MDRWrite = 1'b1;
                    state_d  = (Opcode == OP_LW) ? S_LWWB : S_ALUMEM;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_LWWB: begin
                ACCWrite = 1'b1;
                ACCSrc   = ACC_MDR;
                state_d  = S_FETCH;
            end
            S_ALUMEM: begin
                SrcA     = A_ACC;
                SrcB     = B_MDR;
                ACCWrite = 1'b1;
                ACCSrc   = ACC_ALU;
                case (Opcode)
                    OP_SUB:  ALUOP = ALU_SUB;
                    OP_AND:  ALUOP = ALU_AND;
                    OP_OR:   ALUOP = ALU_OR;
                    default: ALUOP = ALU_ADD;
                endcase
                state_d = S_FETCH;
            end
            S_SW: begin
                MemWrite   = 1'b1;
                MemAddrSrc = MA_ZE;
                if (MemReady) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_ADDI: begin
                SrcA     = A_ACC;
                SrcB     = B_SE;
                ALUOP    = ALU_ADD;
                ACCWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQZ: begin
                SrcA    = A_ACC;
                ALUOP   = ALU_PASSA;
                PCSrc   = PC_ALUOUT;
                PCWrite = Zero;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PC_ZE;
                state_d = S_FETCH;
            end
            S_PUSHSP: begin
                SrcA    = A_SP;
                SrcB    = B_TWO;
                ALUOP   = ALU_SUB;
                SPWrite = 1'b1;
                state_d = S_PUSHWR;
            end
            S_PUSHWR: begin
                MemWrite   = 1'b1;
                MemAddrSrc = MA_SP;
                if (MemReady) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_POPRD: begin
                MemRead    = 1'b1;
                MemAddrSrc = MA_SP;
                if (MemReady) begin
                    MDRWrite = 1'b1;
                    state_d  = S_POPWB;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_POPWB: begin
                ACCWrite = 1'b1;
                ACCSrc   = ACC_MDR;
                SrcA     = A_SP;
                SrcB     = B_TWO;
                ALUOP    = ALU_ADD;
                SPWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end
        endcase

        // Strobes are suppressed while reset is low so an abandoned
        // instruction cannot write anything in the reset cycle.
        if (!reset) begin
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            ALUOutWrite = 1'b0;
            MDRWrite    = 1'b0;
            ACCWrite    = 1'b0;
            SPWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
        end
    end

    assign Halted = (state_q == S_HALT);
    assign Fault  = fault_q;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_acc_control_fsm.sv
// Directed self-checking bench for acc_control_fsm.
module tb_acc_control_fsm;

    logic       CLK = 1'b0;
    logic       reset;
    logic [3:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IRWrite, ALUOutWrite, MDRWrite, ACCWrite, SPWrite;
    logic       MemRead, MemWrite;
    logic [1:0] MemAddrSrc, PCSrc;
    logic       ACCSrc;
    logic [2:0] SrcA, ALUOP;
    logic [3:0] SrcB;
    logic       Halted, Fault;

    int checks = 0;
    int failures = 0;

    acc_control_fsm #(.TIMEOUT(15)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .ALUOutWrite(ALUOutWrite),
        .MDRWrite   (MDRWrite),
        .ACCWrite   (ACCWrite),
        .SPWrite    (SPWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemAddrSrc (MemAddrSrc),
        .PCSrc      (PCSrc),
        .ACCSrc     (ACCSrc),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUOP      (ALUOP),
        .Halted     (Halted),
        .Fault      (Fault)
    );

    always #5 CLK = ~CLK;

    // {PCWrite, IRWrite, ALUOutWrite, MDRWrite, ACCWrite, SPWrite, MemRead, MemWrite}
    logic [7:0] strobes;
    assign strobes = {PCWrite, IRWrite, ALUOutWrite, MDRWrite,
                      ACCWrite, SPWrite, MemRead, MemWrite};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        Opcode   = 4'h0;
        Zero     = 1'b0;
        MemReady = 1'b1;
        #1;
        chk("rst_strobes_pre", strobes, 8'h00);
        tick();
        chk("rst_strobes_c1", strobes, 8'h00);
        tick();
        chk("rst_strobes_c2", strobes, 8'h00);
        chk("rst_halted", Halted, 1'b0);
        chk("rst_fault", Fault, 1'b0);

        // Release: FETCH with zero wait
        Opcode = 4'h3;
        reset  = 1'b1;
        #1;
        chk("fetch_strobes", strobes, 8'b1100_0010);
        chk("fetch_addr", MemAddrSrc, 2'd0);
        chk("fetch_pcsrc", PCSrc, 2'd0);

        // ADD: FETCH, DECODE, MEMRD, ALUMEM
        tick();
        chk("add_dec_strobes", strobes, 8'b0010_0000);
        chk("add_dec_srcb", SrcB, 4'd4);
        tick();
        chk("add_memrd_strobes", strobes, 8'b0001_0010);
        chk("add_memrd_addr", MemAddrSrc, 2'd1);
        tick();
        chk("add_alu_strobes", strobes, 8'b0000_1000);
        chk("add_alu_op", ALUOP, 3'd0);
        chk("add_alu_srcb", SrcB, 4'd2);
        chk("add_alu_srca", SrcA, 3'd1);
        chk("add_alu_accsrc", ACCSrc, 1'b0);

        // SUB: check ALU op in ALUMEM
        tick();
        Opcode = 4'h4;
        #1;
        chk("sub_fetch", strobes, 8'b1100_0010);
        tick(); tick(); tick();
        chk("sub_alu_op", ALUOP, 3'd1);
        chk("sub_alu_strobes", strobes, 8'b0000_1000);

        // LW with three wait cycles in MEMRD
        tick();
        Opcode = 4'h1;
        tick();
        tick();
        MemReady = 1'b0;
        #1;
        chk("lw_wait1", strobes, 8'b0000_0010);
        tick();
        chk("lw_wait2", strobes, 8'b0000_0010);
        tick();
        chk("lw_wait3", strobes, 8'b0000_0010);
        tick();
        MemReady = 1'b1;
        #1;
        chk("lw_ready", strobes, 8'b0001_0010);
        chk("lw_ready_addr", MemAddrSrc, 2'd1);
        tick();
        chk("lw_wb_strobes", strobes, 8'b0000_1000);
        chk("lw_wb_accsrc", ACCSrc, 1'b1);
        tick();
        chk("lw_back_fetch", strobes, 8'b1100_0010);

        // BEQZ taken
        Opcode = 4'h8;
        Zero   = 1'b1;
        tick();
        tick();
        chk("beqz_t_strobes", strobes, 8'b1000_0000);
        chk("beqz_t_pcsrc", PCSrc, 2'd1);
        chk("beqz_t_aluop", ALUOP, 3'd5);
        // BEQZ not taken (latency 3: back in FETCH)
        tick();
        Zero = 1'b0;
        tick();
        tick();
        chk("beqz_nt_strobes", strobes, 8'b0000_0000);
        tick();
        chk("beqz_nt_fetch", strobes, 8'b1100_0010);

        // J
        Opcode = 4'h9;
        tick();
        tick();
        chk("j_strobes", strobes, 8'b1000_0000);
        chk("j_pcsrc", PCSrc, 2'd2);

        // ADDI
        tick();
        Opcode = 4'h7;
        tick();
        tick();
        chk("addi_strobes", strobes, 8'b0000_1000);
        chk("addi_srcb", SrcB, 4'd1);
        chk("addi_srca", SrcA, 3'd1);

        // PUSH
        tick();
        Opcode = 4'hA;
        tick();
        tick();
        chk("push_sp_strobes", strobes, 8'b0000_0100);
        chk("push_sp_aluop", ALUOP, 3'd1);
        chk("push_sp_srca", SrcA, 3'd2);
        tick();
        chk("push_wr_strobes", strobes, 8'b0000_0001);
        chk("push_wr_addr", MemAddrSrc, 2'd2);

        // POP
        tick();
        Opcode = 4'hB;
        tick();
        tick();
        chk("pop_rd_strobes", strobes, 8'b0001_0010);
        chk("pop_rd_addr", MemAddrSrc, 2'd2);
        tick();
        chk("pop_wb_strobes", strobes, 8'b0000_1100);
        chk("pop_wb_accsrc", ACCSrc, 1'b1);
        chk("pop_wb_aluop", ALUOP, 3'd0);

        // SW with one wait cycle
        tick();
        Opcode = 4'h2;
        tick();
        tick();
        MemReady = 1'b0;
        #1;
        chk("sw_wait", strobes, 8'b0000_0001);
        chk("sw_addr", MemAddrSrc, 2'd1);
        tick();
        MemReady = 1'b1;
        #1;
        chk("sw_ready", strobes, 8'b0000_0001);
        tick();
        chk("sw_back_fetch", strobes, 8'b1100_0010);

        // Reset in the middle of LW writeback: no strobes
        Opcode = 4'h1;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("midrst_strobes", strobes, 8'h00);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_fetch", strobes, 8'b1100_0010);

        // Illegal opcode 0xD
        Opcode = 4'hD;
        tick();
        tick();
        chk("ill_halted", Halted, 1'b1);
        chk("ill_fault", Fault, 1'b1);
        chk("ill_strobes", strobes, 8'h00);
        tick();
        tick();
        chk("ill_sticky", {Halted, Fault}, 2'b11);

        // HALT opcode: halted without fault
        do_reset();
        chk("halt_rst_fault", Fault, 1'b0);
        Opcode = 4'h0;
        tick();
        tick();
        chk("halt_halted", Halted, 1'b1);
        chk("halt_fault", Fault, 1'b0);

        // Timeout in FETCH: 15 non-ready cycles
        reset    = 1'b0;
        MemReady = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("to_start", {Halted, Fault}, 2'b00);
        repeat (14) tick();
        chk("to_14_memread", MemRead, 1'b1);
        chk("to_14_halted", Halted, 1'b0);
        tick();
        chk("to_15_halted", Halted, 1'b1);
        chk("to_15_fault", Fault, 1'b1);
        chk("to_15_strobes", strobes, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
